irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Memory-mapped interrupt controller on the picorv32 native bus, directly upstream of the core's `irq` input (currently tied to zero in the SoC top). It collects external interrupt sources and latches or tracks them as pending. Pending sources are masked per source and driven as a registered 32-bit vector into picorv32 `irq`. Decoded in the SoC at 0x80000020–0x8000002F (`(mem_addr & 32'hfffffff0) == 32'h80000020`).

## Interface
Parameters:
- `NUM_SRC`, 8, number of external interrupt sources (1..29).
- `IRQ_BASE`, 3, bit of `irq_o` driven by source 0. Bits 0–2 stay reserved for picorv32 internal IRQs.
- Legal parameter set: `NUM_SRC + IRQ_BASE <= 32`.

Ports:
- `clk`  in  1  system clock; the block has one clock.
- `reset`  in  1  asynchronous, active-high reset.
- `irq_sel`  in  1  access strobe, `mem_valid` && address decode.
- `addr`  in  4  `mem_addr[3:0]`; only `[3:2]` decoded.
- `irq_wstrb`  in  4  byte-lane write enables; all zero means read.
- `irq_di`  in  32  write data.
- `irq_do`  out  32  read data, registered.
- `irq_ready`  out  1  transaction done, one-cycle pulse.
- `src`  in  NUM_SRC  asynchronous interrupt sources, active high.
- `irq_o`  out  32  to picorv32 `irq`, registered.

## Operation
Register map (bit i = source i; bits ≥ NUM_SRC read 0, writes ignored):
- 0x0 PENDING: read pending state. Write-1-to-clear, edge-mode bits only.
- 0x4 ENABLE: read/write mask.
- 0x8 MODE: read/write. 1 = rising-edge latched, 0 = level.
- 0xC FORCE: write-1-to-set pending, edge-mode bits only. Reads 0.

Byte lanes:
- Each write affects only bytes whose `irq_wstrb` bit is set.
- The effective W1C/W1S mask is `irq_di` AND the lane mask.

Source path:
- Each `src[i]` passes through a 2-flop synchronizer, then a third flop for edge detection.
- Rising edge = sync & ~prev.

Pending update, per bit, each cycle:
- Level mode: pending = synced level. W1C and FORCE have no effect.
- Edge mode: set on rising edge or FORCE; cleared by W1C.
- Simultaneous set and clear in the same cycle: set wins.
- Writing MODE from 1 to 0: pending takes the synced level on the next cycle.
- Writing MODE from 0 to 1: pending is held until cleared.

Output: `irq_o[IRQ_BASE+i]` = registered (pending[i] & enable[i]). All other `irq_o` bits = 0.

Bus FSM:
- States: IDLE, ACK.
- IDLE, `irq_sel`=1 → ACK. On this edge: perform the write (if any `irq_wstrb`), capture read data into `irq_do`, assert `irq_ready`.
- ACK → IDLE unconditionally. `irq_ready` deasserts.
- `irq_sel` still high in IDLE after ACK starts a new access. The core drops `mem_valid` after `mem_ready`, so this only happens for back-to-back accesses.
- Read data is the register value before the same-cycle update.
- `irq_do` holds its last value when idle.

## Timing
- Access latency: `irq_ready` is high exactly in the cycle after `irq_sel` rises. Every access is 2 cycles including the select cycle.
- Write effect: visible in register readback from the next access. Visible on `irq_o` one cycle after the register changes.
- Source to `irq_o`: edge on `src` → `irq_o` high 4 `clk` edges later (2 sync, 1 edge/pending, 1 output register).
- Clear to `irq_o` low: 2 edges after the `irq_sel` edge that commits the W1C.

Reset (asynchronous, `reset`=1). All of the following are 0 while reset is held and immediately on assertion:
- Outputs: `irq_o`, `irq_do`, `irq_ready`.
- Internal state: PENDING, ENABLE, MODE, synchronizers, FSM=IDLE.
- Reset mid-access aborts the access: no write is committed, `irq_ready` is not pulsed.

## Test plan
- Reset: drive `src`=8'hFF and `irq_sel` pulses during reset → `irq_o`=0, `irq_ready`=0, all registers read 0 after release.
- Edge latch:
  - Stimulus: MODE=0xFF, ENABLE=0x01, pulse `src[0]` one cycle.
  - Required: `irq_o`=32'h8 four edges later, held after `src` falls. PENDING reads 0x01.
  - Then write PENDING=0x01 → `irq_o`=0 two edges after commit.
- Level mode: MODE=0, ENABLE=0x04, hold `src[2]` high → `irq_o`=32'h20. W1C of bit 2 ignored. `src[2]` low → `irq_o`=0 after 3 edges.
- Masking and lanes:
  - Write ENABLE=32'hFFFFFFFF with `irq_wstrb`=4'b0001 → reads 0x000000FF (NUM_SRC=8).
  - FORCE 0x80 with ENABLE bit 7=0 → PENDING=0x80, `irq_o`=0. Set ENABLE bit 7 → `irq_o`=32'h400.
- Collision: W1C bit 1 committed in the same cycle as `src[1]`'s detected rising edge → PENDING bit 1 stays 1.
- Handshake: hold `irq_sel` high 4 cycles → `irq_ready` pulses on cycles 2 and 4 only. Readback `irq_do` is the pre-write value.

Source files
------------

// File: rtl/irq_ctrl_if.sv
// Bus port bundle for irq_ctrl on the picorv32 native memory bus.
interface irq_ctrl_if;
  logic        irq_sel;
  logic [3:0]  addr;
  logic [3:0]  irq_wstrb;
  logic [31:0] irq_di;
  logic [31:0] irq_do;
  logic        irq_ready;

  modport master (
    output irq_sel, addr, irq_wstrb, irq_di,
    input  irq_do, irq_ready
  );

  modport slave (
    input  irq_sel, addr, irq_wstrb, irq_di,
    output irq_do, irq_ready
  );
endinterface

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller feeding the picorv32 irq input.
// Sources are synchronized, latched or tracked as pending, then masked.
module irq_ctrl #(
  parameter int NUM_SRC  = 8,
  parameter int IRQ_BASE = 3
) (
  input  logic               clk,
  input  logic               reset,
  irq_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] src,
  output logic [31:0]        irq_o
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t state_q, state_d;
  logic   acc, wr;

  logic [NUM_SRC-1:0] s1_q, s2_q, prev_q;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] rise, w1c, w1s;
  logic [NUM_SRC-1:0] lane_m, lane_di;
  logic [31:0]        lmask, rdata;
  logic [31:0]        do_q, irq_d, irq_q;
  logic               rdy_q;
  logic [1:0]         reg_sel;
  logic               unused_bits;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.irq_sel) state_d = ACK;
      ACK:  state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    acc = (state_q == IDLE) && bus.irq_sel;
    wr  = acc && (|bus.irq_wstrb);
  end

  assign reg_sel = bus.addr[3:2];
  assign lmask   = {{8{bus.irq_wstrb[3]}}, {8{bus.irq_wstrb[2]}},
                    {8{bus.irq_wstrb[1]}}, {8{bus.irq_wstrb[0]}}};
  assign lane_m  = lmask[NUM_SRC-1:0];
  assign lane_di = bus.irq_di[NUM_SRC-1:0] & lane_m;

  always_comb begin
    en_d   = en_q;
    mode_d = mode_q;
    w1c    = '0;
    w1s    = '0;
    if (wr) begin
      unique case (reg_sel)
        2'd0: w1c    = lane_di;
        2'd1: en_d   = (en_q & ~lane_m) | lane_di;
        2'd2: mode_d = (mode_q & ~lane_m) | lane_di;
        2'd3: w1s    = lane_di;
      endcase
    end
  end

  assign rise = s2_q & ~prev_q;

  // Level bits load s1 so pending lines up with the 2-flop synced level
  assign pend_d = (mode_q & ((pend_q & ~w1c) | rise | w1s))
                | (~mode_q & s1_q);

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      2'd0: rdata = 32'(pend_q);
      2'd1: rdata = 32'(en_q);
      2'd2: rdata = 32'(mode_q);
      2'd3: rdata = '0;
    endcase
  end

  assign irq_d = 32'(pend_q & en_q) << IRQ_BASE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      pend_q <= '0;
      en_q   <= '0;
      mode_q <= '0;
      do_q   <= '0;
      rdy_q  <= 1'b0;
      irq_q  <= '0;
    end else begin
      s1_q   <= src;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      pend_q <= pend_d;
      en_q   <= en_d;
      mode_q <= mode_d;
      rdy_q  <= acc;
      irq_q  <= irq_d;
      if (acc) do_q <= rdata;
    end
  end

  assign bus.irq_do    = do_q;
  assign bus.irq_ready = rdy_q;
  assign irq_o         = irq_q;

  assign unused_bits = ^{bus.addr[1:0], bus.irq_di, lmask};

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic [31:0] irq_o;
  int          n_checks = 0;
  int          n_fail = 0;

  irq_ctrl_if bus ();

  irq_ctrl #(
    .NUM_SRC  (8),
    .IRQ_BASE (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .src   (src),
    .irq_o (irq_o)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [7:0]  m_en, m_mode, m_pend;
  logic [7:0]  h1, h2, h3;
  logic        m_ack, m_rdy;
  logic [31:0] m_do, m_irq;
  logic        m_acc, m_wr0;

  function automatic logic [7:0] next_pend(
    input logic [7:0] p, mode, lvl, rise, clr, set);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      if (!mode[i])                r[i] = lvl[i];
      else if (set[i] || rise[i])  r[i] = 1'b1;
      else if (clr[i])             r[i] = 1'b0;
      else                         r[i] = p[i];
    end
    return r;
  endfunction

  function automatic logic [31:0] rd_reg(input logic [1:0] r,
    input logic [7:0] p, e, m);
    case (r)
      2'd0:    return {24'd0, p};
      2'd1:    return {24'd0, e};
      2'd2:    return {24'd0, m};
      default: return 32'd0;
    endcase
  endfunction

  assign m_acc = bus.irq_sel && !m_ack;
  assign m_wr0 = m_acc && bus.irq_wstrb[0];

  // h1/h2/h3: src as sampled 1/2/3 edges back.
  // Synced level after this edge is h1; a rising edge seen now is h2 & ~h3.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_en <= 0; m_mode <= 0; m_pend <= 0;
      h1 <= 0; h2 <= 0; h3 <= 0;
      m_ack <= 0; m_rdy <= 0; m_do <= 0; m_irq <= 0;
    end else begin
      h1 <= src; h2 <= h1; h3 <= h2;
      m_ack <= m_acc;
      m_rdy <= m_acc;
      if (m_acc) m_do <= rd_reg(bus.addr[3:2], m_pend, m_en, m_mode);
      if (m_wr0 && bus.addr[3:2] == 2'd1) m_en <= bus.irq_di[7:0];
      if (m_wr0 && bus.addr[3:2] == 2'd2) m_mode <= bus.irq_di[7:0];
      m_pend <= next_pend(m_pend, m_mode, h1, h2 & ~h3,
        (m_wr0 && bus.addr[3:2] == 2'd0) ? bus.irq_di[7:0] : 8'd0,
        (m_wr0 && bus.addr[3:2] == 2'd3) ? bus.irq_di[7:0] : 8'd0);
      m_irq <= {21'd0, m_pend & m_en, 3'd0};
    end
  end

  task automatic access(input logic [3:0] a, input logic [3:0] ws,
                        input logic [31:0] d, output logic [31:0] rd);
    @(negedge clk);
    bus.irq_sel = 1'b1; bus.addr = a; bus.irq_wstrb = ws; bus.irq_di = d;
    @(negedge clk);
    rd = bus.irq_do;
    bus.irq_sel = 1'b0; bus.irq_wstrb = 4'd0;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    reset = 1'b1; src = 8'hFF;
    bus.irq_sel = 0; bus.addr = 4'h4; bus.irq_wstrb = 4'hF;
    bus.irq_di = 32'hFFFF_FFFF;
    repeat (6) begin
      @(negedge clk);
      bus.irq_sel = ~bus.irq_sel;
      n_checks++;
      if (irq_o !== 32'd0) begin
        n_fail++; $display("FAIL reset_irq_o got %h want 0", irq_o);
      end
      n_checks++;
      if (bus.irq_ready !== 1'b0) begin
        n_fail++; $display("FAIL reset_ready got %b want 0", bus.irq_ready);
      end
    end
    bus.irq_sel = 0; bus.irq_wstrb = 0; src = 8'h00;
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      access(4'(k * 4), 4'd0, 32'd0, rd);
      n_checks++;
      if (rd !== 32'd0) begin
        n_fail++; $display("FAIL reset_reg%0d got %h want 0", k, rd);
      end
    end
  endtask

  task automatic test_edge_latch;
    logic [31:0] rd;
    access(4'h8, 4'b0001, 32'hFF, rd);
    access(4'h4, 4'b0001, 32'h01, rd);
    @(negedge clk); src = 8'h01;
    @(negedge clk); src = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'd0) begin
      n_fail++; $display("FAIL edge_early got %h want 0", irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h8) begin
      n_fail++; $display("FAIL edge_4th got %h want 8", irq_o);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h8) begin
      n_fail++; $display("FAIL edge_hold got %h want 8", irq_o);
    end
    access(4'h0, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h01) begin
      n_fail++; $display("FAIL edge_pending got %h want 1", rd);
    end
    access(4'h0, 4'b0001, 32'h01, rd);
    n_checks++;
    if (irq_o !== 32'h8) begin
      n_fail++; $display("FAIL w1c_edge1 got %h want 8", irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'd0) begin
      n_fail++; $display("FAIL w1c_edge2 got %h want 0", irq_o);
    end
  endtask

  task automatic test_level;
    logic [31:0] rd;
    access(4'h8, 4'b0001, 32'h00, rd);
    access(4'h4, 4'b0001, 32'h04, rd);
    @(negedge clk); src = 8'h04;
    repeat (4) @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h20) begin
      n_fail++; $display("FAIL level_on got %h want 20", irq_o);
    end
    access(4'h0, 4'b0001, 32'h04, rd);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h20) begin
      n_fail++; $display("FAIL level_w1c got %h want 20", irq_o);
    end
    access(4'h0, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h04) begin
      n_fail++; $display("FAIL level_pending got %h want 4", rd);
    end
    @(negedge clk); src = 8'h00;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h20) begin
      n_fail++; $display("FAIL level_off2 got %h want 20", irq_o);
    end
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'd0) begin
      n_fail++; $display("FAIL level_off3 got %h want 0", irq_o);
    end
  endtask

  task automatic test_lanes;
    logic [31:0] rd;
    access(4'h4, 4'b0001, 32'hFFFF_FFFF, rd);
    access(4'h4, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'hFF) begin
      n_fail++; $display("FAIL lane_enable got %h want ff", rd);
    end
    access(4'h8, 4'b0010, 32'hFF, rd);
    access(4'h8, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL lane_mode got %h want 0", rd);
    end
    access(4'h4, 4'hF, 32'h7F, rd);
    access(4'h8, 4'b0001, 32'hFF, rd);
    access(4'hC, 4'b0001, 32'h80, rd);
    access(4'h0, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h80) begin
      n_fail++; $display("FAIL force_pending got %h want 80", rd);
    end
    access(4'hC, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'd0) begin
      n_fail++; $display("FAIL force_read got %h want 0", rd);
    end
    n_checks++;
    if (irq_o !== 32'd0) begin
      n_fail++; $display("FAIL force_masked got %h want 0", irq_o);
    end
    access(4'h4, 4'b0001, 32'hFF, rd);
    @(negedge clk);
    n_checks++;
    if (irq_o !== 32'h400) begin
      n_fail++; $display("FAIL force_unmask got %h want 400", irq_o);
    end
  endtask

  task automatic test_collision;
    logic [31:0] rd;
    access(4'h0, 4'b0001, 32'hFF, rd);
    @(negedge clk); src = 8'h02;
    @(negedge clk);
    @(negedge clk);
    bus.irq_sel = 1; bus.addr = 4'h0; bus.irq_wstrb = 4'b0001;
    bus.irq_di = 32'h02;
    @(negedge clk);
    bus.irq_sel = 0; bus.irq_wstrb = 0;
    access(4'h0, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h02) begin
      n_fail++; $display("FAIL collision got %h want 2", rd);
    end
    src = 8'h00;
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    @(negedge clk);
    bus.irq_sel = 1; bus.addr = 4'h4; bus.irq_wstrb = 4'b0001;
    bus.irq_di = 32'h55;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.irq_ready !== (c % 2 == 0)) begin
        n_fail++;
        $display("FAIL b2b_ready%0d got %b want %b", c, bus.irq_ready,
                 (c % 2 == 0));
      end
      if (c == 0) begin
        n_checks++;
        if (bus.irq_do !== 32'hFF) begin
          n_fail++; $display("FAIL b2b_do0 got %h want ff", bus.irq_do);
        end
      end
      if (c == 2) begin
        n_checks++;
        if (bus.irq_do !== 32'h55) begin
          n_fail++; $display("FAIL b2b_do2 got %h want 55", bus.irq_do);
        end
      end
    end
    bus.irq_sel = 0; bus.irq_wstrb = 0;
    access(4'h4, 4'd0, 32'd0, rd);
    n_checks++;
    if (rd !== 32'h55) begin
      n_fail++; $display("FAIL b2b_final got %h want 55", rd);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      n_checks++;
      if (irq_o !== m_irq) begin
        n_fail++; $display("FAIL rand_irq cyc %0d got %h want %h", i, irq_o, m_irq);
      end
      n_checks++;
      if (bus.irq_ready !== m_rdy) begin
        n_fail++;
        $display("FAIL rand_ready cyc %0d got %b want %b", i, bus.irq_ready, m_rdy);
      end
      n_checks++;
      if (bus.irq_do !== m_do) begin
        n_fail++;
        $display("FAIL rand_do cyc %0d got %h want %h", i, bus.irq_do, m_do);
      end
      if ($urandom_range(0, 3) == 0)
        src = src ^ 8'($urandom_range(0, 255));
      bus.irq_sel   = ($urandom_range(0, 2) == 0);
      bus.addr      = 4'($urandom_range(0, 15));
      bus.irq_wstrb = $urandom_range(0, 1) ? 4'd0 : 4'($urandom);
      bus.irq_di    = $urandom;
    end
    bus.irq_sel = 0; bus.irq_wstrb = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_edge_latch;
    test_level;
    test_lanes;
    test_collision;
    test_back_to_back;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
